// File: rtl/param_shift_register.sv
// W-bit x M-stage activation shift register: serial shift, parallel load, rotate.
// Optional nonzero-cell counter enabled by PARAM_SHIFT_REGISTER_NZ_EN.
module param_shift_register #(
  parameter  int W  = 8,
  parameter  int M  = 10,
  localparam int CW = $clog2(M + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           shift_en,
  input  logic           rotate,
  input  logic           load_en,
  input  logic [W-1:0]   data_in,
  input  logic [M*W-1:0] par_in,
  output logic [W-1:0]   data_out,
  output logic [M*W-1:0] po,
`ifdef PARAM_SHIFT_REGISTER_NZ_EN
  output logic [CW-1:0]  nz_count,
  output logic           single_nz,
`endif
  output logic [CW-1:0]  fill_count,
  output logic           full,
  output logic           empty
);

  localparam logic [CW-1:0] FILL_MAX = CW'(M);

  logic [M-1:0][W-1:0] cells_q, cells_d;
  logic [CW-1:0]       fill_q, fill_d;

  // Next-state: load beats shift; rotate only matters while shifting.
  always_comb begin
    cells_d = cells_q;
    fill_d  = fill_q;
    if (load_en) begin
      cells_d = par_in;
      fill_d  = FILL_MAX;
    end else if (shift_en) begin
      for (int i = 1; i < M; i++) begin
        cells_d[i] = cells_q[i-1];
      end
      if (rotate) begin
        cells_d[0] = cells_q[M-1];
      end else begin
        cells_d[0] = data_in;
        if (fill_q != FILL_MAX) begin
          fill_d = fill_q + CW'(1);
        end
      end
    end
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cells_q <= '0;
      fill_q  <= '0;
    end else begin
      cells_q <= cells_d;
      fill_q  <= fill_d;
    end
  end

  assign po         = cells_q;
  assign data_out   = cells_q[M-1];
  assign fill_count = fill_q;
  assign full       = (fill_q == FILL_MAX);
  assign empty      = (fill_q == '0);

`ifdef PARAM_SHIFT_REGISTER_NZ_EN
  logic [CW-1:0] nz_cnt;

  // Population count of nonzero cells; one survivor means a winner.
  always_comb begin
    nz_cnt = '0;
    for (int i = 0; i < M; i++) begin
      if (cells_q[i] != '0) begin
        nz_cnt = nz_cnt + CW'(1);
      end
    end
  end

  assign nz_count  = nz_cnt;
  assign single_nz = (nz_cnt == CW'(1));
`endif

endmodule

// File: tb/tb_param_shift_register.sv
// Directed self-checking bench for param_shift_register.
// Covers reset, fill, load priority, rotate and mid-run reset.
module tb_param_shift_register;

  localparam int W  = 8;
  localparam int M  = 10;
  localparam int CW = $clog2(M + 1);

  logic           clk;
  logic           reset;
  logic           shift_en;
  logic           rotate;
  logic           load_en;
  logic [W-1:0]   data_in;
  logic [M*W-1:0] par_in;
  logic [W-1:0]   data_out;
  logic [M*W-1:0] po;
  logic [CW-1:0]  fill_count;
  logic           full;
  logic           empty;
`ifdef PARAM_SHIFT_REGISTER_NZ_EN
  logic [CW-1:0]  nz_count;
  logic           single_nz;
`endif

  int errs;
  int checks;
  logic [M*W-1:0] exp_po;

  param_shift_register #(.W(W), .M(M)) dut (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (shift_en),
    .rotate    (rotate),
    .load_en   (load_en),
    .data_in   (data_in),
    .par_in    (par_in),
    .data_out  (data_out),
    .po        (po),
`ifdef PARAM_SHIFT_REGISTER_NZ_EN
    .nz_count  (nz_count),
    .single_nz (single_nz),
`endif
    .fill_count(fill_count),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset    = 1'b1;
    shift_en = 1'b0;
    rotate   = 1'b0;
    load_en  = 1'b0;
    data_in  = '0;
    par_in   = '0;
  endtask

  task automatic test_reset();
    idle();
    reset    = 1'b0;
    shift_en = 1'b1;
    data_in  = 8'hAA;
    tick();
    tick();
    checks++;
    if (po !== '0) begin
      errs++; $display("FAIL reset_po: got %h expected 0", po);
    end
    checks++;
    if (fill_count !== CW'(0)) begin
      errs++; $display("FAIL reset_fill: got %0d expected 0", fill_count);
    end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      errs++; $display("FAIL reset_flags: got empty=%b full=%b expected 1 0", empty, full);
    end
    checks++;
    if (data_out !== 8'h00) begin
      errs++; $display("FAIL reset_dout: got %h expected 00", data_out);
    end
`ifdef PARAM_SHIFT_REGISTER_NZ_EN
    checks++;
    if (nz_count !== CW'(0) || single_nz !== 1'b0) begin
      errs++; $display("FAIL reset_nz: got %0d/%b expected 0/0", nz_count, single_nz);
    end
`endif
    idle();
  endtask

  task automatic test_serial_fill();
    idle();
    shift_en = 1'b1;
    for (int k = 1; k <= M; k++) begin
      data_in = W'(k);
      tick();
      checks++;
      if (fill_count !== CW'(k)) begin
        errs++; $display("FAIL fill_step%0d: got %0d expected %0d", k, fill_count, k);
      end
    end
    checks++;
    if (po[W-1:0] !== 8'd10) begin
      errs++; $display("FAIL fill_po0: got %h expected 0a", po[W-1:0]);
    end
    checks++;
    if (data_out !== 8'd1) begin
      errs++; $display("FAIL fill_dout: got %h expected 01", data_out);
    end
    checks++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      errs++; $display("FAIL fill_flags: got full=%b empty=%b expected 1 0", full, empty);
    end
    data_in = 8'h0B;
    tick();
    checks++;
    if (data_out !== 8'd2) begin
      errs++; $display("FAIL sat_dout: got %h expected 02", data_out);
    end
    checks++;
    if (fill_count !== CW'(M)) begin
      errs++; $display("FAIL sat_fill: got %0d expected %0d", fill_count, M);
    end
    checks++;
    if (po[W-1:0] !== 8'h0B) begin
      errs++; $display("FAIL sat_po0: got %h expected 0b", po[W-1:0]);
    end
    idle();
  endtask

  task automatic test_load_priority();
    idle();
    for (int i = 0; i < M; i++) begin
      exp_po[i*W +: W] = 8'h10 + W'(i);
    end
    par_in   = exp_po;
    load_en  = 1'b1;
    shift_en = 1'b1;
    data_in  = 8'hFF;
    tick();
    checks++;
    if (po !== exp_po) begin
      errs++; $display("FAIL load_po: got %h expected %h", po, exp_po);
    end
    checks++;
    if (fill_count !== CW'(M)) begin
      errs++; $display("FAIL load_fill: got %0d expected %0d", fill_count, M);
    end
    checks++;
    if (data_out !== 8'h19) begin
      errs++; $display("FAIL load_dout: got %h expected 19", data_out);
    end
    idle();
  endtask

  task automatic test_rotate();
    idle();
    rotate = 1'b1;
    tick();
    checks++;
    if (po !== exp_po) begin
      errs++; $display("FAIL rot_noshift: got %h expected %h", po, exp_po);
    end
    shift_en = 1'b1;
    data_in  = 8'hEE;
    tick();
    checks++;
    if (po[W-1:0] !== 8'h19 || po[2*W-1:W] !== 8'h10) begin
      errs++; $display("FAIL rot1_po: got %h %h expected 19 10", po[W-1:0], po[2*W-1:W]);
    end
    checks++;
    if (data_out !== 8'h18) begin
      errs++; $display("FAIL rot1_dout: got %h expected 18", data_out);
    end
    for (int k = 1; k < M; k++) begin
      tick();
    end
    checks++;
    if (po !== exp_po) begin
      errs++; $display("FAIL rot10_po: got %h expected %h", po, exp_po);
    end
    checks++;
    if (fill_count !== CW'(M)) begin
      errs++; $display("FAIL rot10_fill: got %0d expected %0d", fill_count, M);
    end
    idle();
    tick();
    checks++;
    if (po !== exp_po) begin
      errs++; $display("FAIL hold_po: got %h expected %h", po, exp_po);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    reset = 1'b0;
    tick();
    idle();
    shift_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      data_in = 8'h21 + W'(k);
      tick();
    end
    checks++;
    if (fill_count !== CW'(3)) begin
      errs++; $display("FAIL mid_fill3: got %0d expected 3", fill_count);
    end
    shift_en = 1'b0;
    reset    = 1'b0;
    load_en  = 1'b1;
    par_in   = {M{8'h5A}};
    tick();
    checks++;
    if (po !== '0 || fill_count !== CW'(0) || empty !== 1'b1) begin
      errs++; $display("FAIL mid_reset: got po=%h fill=%0d empty=%b expected 0 0 1", po, fill_count, empty);
    end
    idle();
    shift_en = 1'b1;
    data_in  = 8'h05;
    tick();
    checks++;
    if (po[W-1:0] !== 8'h05 || fill_count !== CW'(1)) begin
      errs++; $display("FAIL mid_shift: got po0=%h fill=%0d expected 05 1", po[W-1:0], fill_count);
    end
    idle();
  endtask

`ifdef PARAM_SHIFT_REGISTER_NZ_EN
  task automatic test_nz();
    idle();
    par_in = '0;
    par_in[2*W +: W] = 8'h07;
    load_en = 1'b1;
    tick();
    checks++;
    if (nz_count !== CW'(1) || single_nz !== 1'b1) begin
      errs++; $display("FAIL nz_one: got %0d/%b expected 1/1", nz_count, single_nz);
    end
    idle();
    shift_en = 1'b1;
    data_in  = 8'h03;
    tick();
    checks++;
    if (nz_count !== CW'(2) || single_nz !== 1'b0) begin
      errs++; $display("FAIL nz_two: got %0d/%b expected 2/0", nz_count, single_nz);
    end
    idle();
  endtask
`endif

  initial begin
    errs   = 0;
    checks = 0;
    exp_po = '0;
    idle();
    test_reset();
    test_serial_fill();
    test_load_priority();
    test_rotate();
    test_reset_mid();
`ifdef PARAM_SHIFT_REGISTER_NZ_EN
    test_nz();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
